load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline load/store request into a single memory
// transaction and returns one writeback response with exception information.
module load_store_unit #(
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT__LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req__valid,
    output logic        req__ready,
    input  logic        req__we,
    input  logic [2:0]  req__funct3,
    input  logic [63:0] req__base,
    input  logic [11:0] req__offset,
    input  logic [63:0] req__data,
    input  logic [4:0]  req__rd,
    output logic        cpu_to_mem__valid,
    output logic        cpu_to_mem__we,
    output logic [63:0] cpu_to_mem__addr,
    output logic [2:0]  cpu_to_mem__dtype,
    output logic [63:0] cpu_to_mem__data,
    input  logic        mem_to_cpu__valid,
    input  logic        mem_to_cpu__error,
    input  logic [63:0] mem_to_cpu__data,
    output logic        rsp__valid,
    input  logic        rsp__ready,
    output logic [63:0] rsp__data,
    output logic [4:0]  rsp__rd,
    output logic        rsp__exc,
    output logic [3:0]  rsp__cause,
    output logic [63:0] rsp__tval
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [TIMEOUT__LOG2-1:0] TO_LAST = TIMEOUT__LOG2'(TIMEOUT - 1);

    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_LD_FAULT  = 4'd4;
    localparam logic [3:0] CAUSE_LD_TMO    = 4'd5;
    localparam logic [3:0] CAUSE_ST_FAULT  = 4'd6;
    localparam logic [3:0] CAUSE_ST_TMO    = 4'd7;

    state_t                    state_q, state_d;
    logic [TIMEOUT__LOG2-1:0]  cnt_q, cnt_d;
    logic                      we_q, we_d;
    logic [4:0]                rd_q, rd_d;
    logic [63:0]               data_q, data_d;
    logic [2:0]                dtype_q, dtype_d;
    logic [63:0]               addr_q, addr_d;
    logic [63:0]               rsp_data_q, rsp_data_d;
    logic                      exc_q, exc_d;
    logic [3:0]                cause_q, cause_d;
    logic [63:0]               tval_q, tval_d;

    logic [2:0]                dec_dtype;
    logic                      dec_legal;
    logic [63:0]               eff_addr;

    // Stores only have the unsigned-free encodings 000..011; funct3 1xx is a load-only extension.
    always_comb begin
        dec_dtype = 3'd0;
        dec_legal = 1'b1;
        case (req__funct3)
            3'b011: dec_dtype = 3'd0;
            3'b010: dec_dtype = 3'd1;
            3'b001: dec_dtype = 3'd3;
            3'b000: dec_dtype = 3'd5;
            3'b110: begin dec_dtype = 3'd2; dec_legal = !req__we; end
            3'b101: begin dec_dtype = 3'd4; dec_legal = !req__we; end
            3'b100: begin dec_dtype = 3'd6; dec_legal = !req__we; end
            default: dec_legal = 1'b0;
        endcase
    end

    assign eff_addr = req__base + {{52{req__offset[11]}}, req__offset};

    always_comb begin
        // NOTE: every next-state variable is defaulted to its current value first so no latch can be inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        rd_d       = rd_q;
        data_d     = data_q;
        dtype_d    = dtype_q;
        addr_d     = addr_q;
        rsp_data_d = rsp_data_q;
        exc_d      = exc_q;
        cause_d    = cause_q;
        tval_d     = tval_q;

        case (state_q)
            IDLE: begin
                if (req__valid) begin
                    we_d    = req__we;
                    rd_d    = req__rd;
                    data_d  = req__data;
                    dtype_d = dec_dtype;
                    addr_d  = eff_addr;
                    if (dec_legal) begin
                        state_d = ISSUE;
                    end else begin
                        state_d    = RESP;
                        rsp_data_d = 64'd0;
                        exc_d      = 1'b1;
                        cause_d    = CAUSE_ILLEGAL;
                        tval_d     = 64'd0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A response arriving on the timeout cycle still wins.
                if (mem_to_cpu__valid) begin
                    state_d = RESP;
                    if (mem_to_cpu__error) begin
                        rsp_data_d = 64'd0;
                        exc_d      = 1'b1;
                        cause_d    = we_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                        tval_d     = addr_q;
                    end else begin
                        rsp_data_d = we_q ? 64'd0 : mem_to_cpu__data;
                        exc_d      = 1'b0;
                        cause_d    = 4'd0;
                        tval_d     = 64'd0;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d    = RESP;
                    rsp_data_d = 64'd0;
                    exc_d      = 1'b1;
                    cause_d    = we_q ? CAUSE_ST_TMO : CAUSE_LD_TMO;
                    tval_d     = addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp__ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            rd_q       <= 5'd0;
            data_q     <= 64'd0;
            dtype_q    <= 3'd0;
            addr_q     <= 64'd0;
            rsp_data_q <= 64'd0;
            exc_q      <= 1'b0;
            cause_q    <= 4'd0;
            tval_q     <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            dtype_q    <= dtype_d;
            addr_q     <= addr_d;
            rsp_data_q <= rsp_data_d;
            exc_q      <= exc_d;
            cause_q    <= cause_d;
            tval_q     <= tval_d;
        end
    end

    assign req__ready        = (state_q == IDLE);
    assign cpu_to_mem__valid = (state_q == ISSUE);
    assign cpu_to_mem__we    = we_q;
    assign cpu_to_mem__addr  = addr_q;
    assign cpu_to_mem__dtype = dtype_q;
    assign cpu_to_mem__data  = data_q;

    assign rsp__valid = (state_q == RESP);
    assign rsp__data  = rsp_data_q;
    assign rsp__rd    = rd_q;
    assign rsp__exc   = exc_q;
    assign rsp__cause = cause_q;
    assign rsp__tval  = tval_q;

endmodule
